// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit word memory port between 4-beat icache refills and single-beat dcache accesses.
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution; otherwise the dcache wins every conflict.
module mem_port_arbiter (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         I_READ,
    input  logic [5:0]   I_ADDRESS,
    output logic [127:0] I_READDATA,
    output logic         I_BUSYWAIT,
    input  logic         D_READ,
    input  logic         D_WRITE,
    input  logic [5:0]   D_ADDRESS,
    input  logic [31:0]  D_WRITEDATA,
    output logic [31:0]  D_READDATA,
    output logic         D_BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [8:0]   MEM_ADDRESS,
    output logic [31:0]  MEM_WRITEDATA,
    input  logic [31:0]  MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BEAT = 3'd1,
        I_GAP  = 3'd2,
        I_DONE = 3'd3,
        D_BEAT = 3'd4,
        D_DONE = 3'd5
    } state_t;

    state_t     state;
    logic [1:0] beat;
    logic       armed;
    logic       d_req;
    logic       grant_i;

    function automatic logic [8:0] i_word(input logic [5:0] addr, input logic [1:0] b);
        return {1'b0, addr, b};
    endfunction

    function automatic logic [8:0] d_word(input logic [5:0] addr);
        return {3'b100, addr};
    endfunction

    assign d_req = D_READ | D_WRITE;

`ifdef MEM_ARB_RR_EN
    // Conflict preference starts with the dcache and flips after every simultaneous request.
    logic prio_i;

    assign grant_i = I_READ & (~d_req | prio_i);

    always_ff @(posedge CLK) begin
        if (RESET)
            prio_i <= 1'b0;
        else if (state == IDLE && I_READ && d_req)
            prio_i <= ~prio_i;
    end
`else
    assign grant_i = I_READ & ~d_req;
`endif

    assign I_BUSYWAIT = I_READ & (state != I_DONE);
    assign D_BUSYWAIT = d_req  & (state != D_DONE);

    // armed marks that one edge has passed since the strobe rose, so a beat never completes
    // on the edge that raised it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            beat          <= 2'd0;
            armed         <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= 9'd0;
            MEM_WRITEDATA <= 32'd0;
            I_READDATA    <= 128'd0;
            D_READDATA    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    armed <= 1'b0;
                    if (grant_i) begin
                        state       <= I_BEAT;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= i_word(I_ADDRESS, 2'd0);
                    end else if (d_req) begin
                        state         <= D_BEAT;
                        MEM_READ      <= D_READ;
                        MEM_WRITE     <= D_WRITE;
                        MEM_ADDRESS   <= d_word(D_ADDRESS);
                        MEM_WRITEDATA <= D_WRITE ? D_WRITEDATA : 32'd0;
                    end
                end
                I_BEAT: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else if (!MEM_BUSYWAIT) begin
                        armed                       <= 1'b0;
                        MEM_READ                    <= 1'b0;
                        I_READDATA[{beat, 5'd0} +: 32] <= MEM_READDATA;
                        if (beat == 2'd3) begin
                            beat  <= 2'd0;
                            state <= I_DONE;
                        end else begin
                            beat  <= beat + 2'd1;
                            state <= I_GAP;
                        end
                    end
                end
                I_GAP: begin
                    MEM_READ    <= 1'b1;
                    MEM_ADDRESS <= i_word(I_ADDRESS, beat);
                    state       <= I_BEAT;
                end
                I_DONE: begin
                    state <= IDLE;
                end
                D_BEAT: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else if (!MEM_BUSYWAIT) begin
                        armed         <= 1'b0;
                        MEM_READ      <= 1'b0;
                        MEM_WRITE     <= 1'b0;
                        MEM_WRITEDATA <= 32'd0;
                        if (MEM_READ)
                            D_READDATA <= MEM_READDATA;
                        state <= D_DONE;
                    end
                end
                D_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
